// File: rtl/bist_misr_analyzer.sv
// BIST output-response analyser: compacts CUT responses into a Galois MISR over
// N_CYCLES valid cycles, then compares against GOLDEN. Optional BIST_ERR_COUNT_EN adds err_cnt.
module bist_misr_analyzer #(
    parameter int               WIDTH    = 8,
    parameter int               DIN_W    = 2,
    parameter logic [WIDTH-1:0] POLY     = 8'h1D,
    parameter logic [WIDTH-1:0] SEED     = 8'h00,
    parameter int               N_CYCLES = 1000,
    parameter int               CNT_W    = 10,
    parameter logic [WIDTH-1:0] GOLDEN   = 8'h00
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             din_valid,
    input  logic [DIN_W-1:0] din,
    output logic [WIDTH-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             pass_fail
`ifdef BIST_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CYCLES - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] misr_q, misr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pf_q, pf_d;
    logic [WIDTH-1:0] din_ext;
    logic [WIDTH-1:0] misr_step;
`ifdef BIST_ERR_COUNT_EN
    logic [CNT_W-1:0] err_q, err_d;
`endif

    assign din_ext   = WIDTH'(din);
    // Galois step: shift left, fold POLY back in when the MSB falls out, then absorb din.
    assign misr_step = {misr_q[WIDTH-2:0], 1'b0} ^ (misr_q[WIDTH-1] ? POLY : '0) ^ din_ext;

    always_comb begin
        state_d = state_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pf_d    = pf_q;
`ifdef BIST_ERR_COUNT_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    misr_d  = SEED;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pf_d    = 1'b0;
`ifdef BIST_ERR_COUNT_EN
                    err_d   = '0;
`endif
                end
            end
            S_RUN: begin
                if (din_valid) begin
                    misr_d = misr_step;
                    cnt_d  = cnt_q + CNT_W'(1);
`ifdef BIST_ERR_COUNT_EN
                    if (din_ext[1] && (err_q != '1)) begin
                        err_d = err_q + CNT_W'(1);
                    end
`endif
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pf_d    = (misr_step == GOLDEN);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            misr_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pf_q    <= 1'b0;
`ifdef BIST_ERR_COUNT_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pf_q    <= pf_d;
`ifdef BIST_ERR_COUNT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign signature = misr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass_fail = pf_q;
`ifdef BIST_ERR_COUNT_EN
    assign err_cnt   = err_q;
`endif

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Scoreboard bench for bist_misr_analyzer: three instances (N=1000, N=8 seed 01, N=1);
// stimulus pushes expected signatures/done events, a negedge monitor pops and compares.
module tb_bist_misr_analyzer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start     [3];
    logic       din_valid [3];
    logic [1:0] din       [3];
    logic [7:0] sig       [3];
    logic       busy      [3];
    logic       done      [3];
    logic       pass_fail [3];
`ifdef BIST_ERR_COUNT_EN
    logic [9:0] err_cnt   [3];
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         id;
        logic [7:0] sig;
        logic       pf;
        int         cyc;
    } done_exp_t;

    done_exp_t  done_q[$];
    logic [7:0] sig_q[$];
    logic [7:0] exp2[8];
    logic [7:0] exp6[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bist_misr_analyzer #(.SEED(8'h00), .N_CYCLES(1000), .CNT_W(10), .GOLDEN(8'h00)) u_a (
        .CLK(clk), .RST(rst_n), .start(start[0]), .din_valid(din_valid[0]), .din(din[0]),
        .signature(sig[0]), .busy(busy[0]), .done(done[0]), .pass_fail(pass_fail[0])
`ifdef BIST_ERR_COUNT_EN
        , .err_cnt(err_cnt[0])
`endif
    );

    bist_misr_analyzer #(.SEED(8'h01), .N_CYCLES(8), .CNT_W(10), .GOLDEN(8'h00)) u_b (
        .CLK(clk), .RST(rst_n), .start(start[1]), .din_valid(din_valid[1]), .din(din[1]),
        .signature(sig[1]), .busy(busy[1]), .done(done[1]), .pass_fail(pass_fail[1])
`ifdef BIST_ERR_COUNT_EN
        , .err_cnt(err_cnt[1])
`endif
    );

    bist_misr_analyzer #(.SEED(8'h00), .N_CYCLES(1), .CNT_W(10), .GOLDEN(8'h00)) u_c (
        .CLK(clk), .RST(rst_n), .start(start[2]), .din_valid(din_valid[2]), .din(din[2]),
        .signature(sig[2]), .busy(busy[2]), .done(done[2]), .pass_fail(pass_fail[2])
`ifdef BIST_ERR_COUNT_EN
        , .err_cnt(err_cnt[2])
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: a valid edge on u_b presents a new signature; a done rising edge presents a result.
    logic      prev_busy_b  = 1'b0;
    logic      prev_valid_b = 1'b0;
    logic      prev_done [3] = '{1'b0, 1'b0, 1'b0};
    done_exp_t m_e;
    logic [7:0] m_s;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy_b  = 1'b0;
            prev_valid_b = 1'b0;
            for (int i = 0; i < 3; i++) prev_done[i] = 1'b0;
        end else begin
            if (prev_busy_b && prev_valid_b) begin
                if (sig_q.size() == 0) begin
                    check("sig_unexpected", 32'd1, 32'd0);
                end else begin
                    m_s = sig_q.pop_front();
                    check("step_sig_u1", 32'(sig[1]), 32'(m_s));
                    $display("step u1 sig=%02h expected=%02h", sig[1], m_s);
                end
            end
            prev_busy_b  = busy[1];
            prev_valid_b = din_valid[1];
            for (int i = 0; i < 3; i++) begin
                if (done[i] && !prev_done[i]) begin
                    if (done_q.size() == 0) begin
                        check($sformatf("done_unexpected_u%0d", i), 32'd1, 32'd0);
                    end else begin
                        m_e = done_q.pop_front();
                        check($sformatf("done_id_u%0d", i), 32'(i), 32'(m_e.id));
                        check($sformatf("done_sig_u%0d", i), 32'(sig[i]), 32'(m_e.sig));
                        check($sformatf("done_pf_u%0d", i), 32'(pass_fail[i]), 32'(m_e.pf));
                        check($sformatf("done_cycle_u%0d", i), 32'(cyc), 32'(m_e.cyc));
                        $display("done u%0d sig=%02h pf=%0b cyc=%0d", i, sig[i], pass_fail[i], cyc);
                    end
                end
                prev_done[i] = done[i];
            end
        end
    end

    task automatic start_run(input int i);
        @(posedge clk); #1;
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
    endtask

    task automatic drive(input int i, input logic v, input logic [1:0] d);
        din_valid[i] = v;
        din[i]       = d;
        @(posedge clk); #1;
        din_valid[i] = 1'b0;
    endtask

    task automatic push_done(input int id, input logic [7:0] s, input logic pf);
        done_exp_t e;
        e.id  = id;
        e.sig = s;
        e.pf  = pf;
        e.cyc = cyc + 1;
        done_q.push_back(e);
    endtask

    task automatic run_t2();
        start_run(1);
        for (int k = 0; k < 8; k++) begin
            sig_q.push_back(exp2[k]);
            if (k == 7) push_done(1, 8'h1D, 1'b0);
            drive(1, 1'b1, 2'b00);
        end
    endtask

    initial begin
        int c0;
        exp2 = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D};
        exp6 = '{8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h3C, 8'h78, 8'hF0};
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0; din_valid[i] = 1'b0; din[i] = 2'b00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_sig_u%0d", i), 32'(sig[i]), 32'h0);
            check($sformatf("rst_busy_u%0d", i), 32'(busy[i]), 32'h0);
            check($sformatf("rst_done_u%0d", i), 32'(done[i]), 32'h0);
            check($sformatf("rst_pf_u%0d", i), 32'(pass_fail[i]), 32'h0);
        end
        rst_n = 1'b1;

        // Test 1: 1000 zero responses from seed 0 match golden 0.
        start_run(0);
        check("t1_busy", 32'(busy[0]), 32'h1);
        for (int k = 0; k < 1000; k++) begin
            if (k == 999) push_done(0, 8'h00, 1'b1);
            drive(0, 1'b1, 2'b00);
        end

        // Test 2: seed 01 walks 02..80 then folds to 1D.
        run_t2();
        repeat (3) @(posedge clk);
        #1;
        check("t2_hold_done", 32'(done[1]), 32'h1);
        check("t2_hold_sig", 32'(sig[1]), 32'h1D);
        check("t2_hold_pf", 32'(pass_fail[1]), 32'h0);
        check("t2_hold_busy", 32'(busy[1]), 32'h0);

        // Test 4: valid on alternate cycles, same final signature after 16 RUN cycles.
        start_run(1);
        check("t4_restart_done", 32'(done[1]), 32'h0);
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 1) begin
                sig_q.push_back(exp2[k / 2]);
                if (k == 15) push_done(1, 8'h1D, 1'b0);
                drive(1, 1'b1, 2'b00);
            end else begin
                drive(1, 1'b0, 2'b00);
            end
        end

        // Test 3: N=1 run completes one edge after its only valid.
        start_run(2);
        push_done(2, 8'h01, 1'b0);
        drive(2, 1'b1, 2'b01);

        // start held high: a new result every two cycles.
        @(posedge clk); #1;
        c0 = cyc;
        for (int r = 1; r <= 3; r++) begin
            done_exp_t e;
            e.id = 2; e.sig = 8'h01; e.pf = 1'b0; e.cyc = c0 + 2 * r;
            done_q.push_back(e);
        end
        start[2] = 1'b1; din_valid[2] = 1'b1; din[2] = 2'b01;
        repeat (6) @(posedge clk);
        #1;
        start[2] = 1'b0; din_valid[2] = 1'b0;

        // Test 5: reset mid-run aborts, then a fresh run still reaches 1D.
        start_run(1);
        for (int k = 0; k < 3; k++) begin
            sig_q.push_back(exp2[k]);
            drive(1, 1'b1, 2'b00);
        end
        din_valid[1] = 1'b1;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_sig", 32'(sig[1]), 32'h0);
        check("t5_rst_busy", 32'(busy[1]), 32'h0);
        check("t5_rst_done", 32'(done[1]), 32'h0);
        sig_q.delete();
        done_q.delete();
        @(posedge clk); #1;
        din_valid[1] = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t5_post_pf", 32'(pass_fail[1]), 32'h0);
        run_t2();

`ifdef BIST_ERR_COUNT_EN
        // Test 6: five error-flagged responses counted and held, cleared on restart.
        start_run(1);
        for (int k = 0; k < 8; k++) begin
            sig_q.push_back(exp6[k]);
            if (k == 7) push_done(1, 8'hF0, 1'b0);
            drive(1, 1'b1, (k < 5) ? 2'b10 : 2'b00);
        end
        repeat (2) @(posedge clk);
        #1;
        check("t6_err_cnt_held", 32'(err_cnt[1]), 32'd5);
        start_run(1);
        check("t6_err_cnt_clear", 32'(err_cnt[1]), 32'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("sig_q_leftover", 32'(sig_q.size()), 32'd0);
        check("done_q_leftover", 32'(done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
